// File: rtl/memory_arbiter_if.sv
// Bundle of the two requester channels and the memory_unit pins for memory_arbiter.
// The arbiter takes the slave modport; requesters and the memory_unit side take master.
interface memory_arbiter_if #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8
);

  // Requester A channel
  logic              a_valid;
  logic              a_ready;
  logic              a_we;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata;
  logic              a_rsp_valid;
  logic [DATA_W-1:0] a_rsp_rdata;

  // Requester B channel
  logic              b_valid;
  logic              b_ready;
  logic              b_we;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata;
  logic              b_rsp_valid;
  logic [DATA_W-1:0] b_rsp_rdata;

  // memory_unit pins
  logic              mem_select;
  logic              mem_op;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data_in;
  logic [DATA_W-1:0] mem_data_out;

  // Status
  logic              busy;

  modport slave (
    input  a_valid, a_we, a_addr, a_wdata,
    output a_ready, a_rsp_valid, a_rsp_rdata,
    input  b_valid, b_we, b_addr, b_wdata,
    output b_ready, b_rsp_valid, b_rsp_rdata,
    output mem_select, mem_op, mem_addr, mem_data_in,
    input  mem_data_out,
    output busy
  );

  modport master (
    output a_valid, a_we, a_addr, a_wdata,
    input  a_ready, a_rsp_valid, a_rsp_rdata,
    output b_valid, b_we, b_addr, b_wdata,
    input  b_ready, b_rsp_valid, b_rsp_rdata,
    input  mem_select, mem_op, mem_addr, mem_data_in,
    output mem_data_out,
    input  busy
  );

endinterface

// File: rtl/memory_arbiter.sv
// Two-requester round-robin arbiter and sequencer for the 8x8 memory_unit.
// One transaction at a time: IDLE (accept) -> ISSUE (select) -> WAIT (capture) -> RESP (pulse).
module memory_arbiter #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  memory_arbiter_if.slave      bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  logic [1:0]        state;
  logic              ptr;        // 0 = A has priority, 1 = B has priority
  logic              gnt_id;     // 0 = A, 1 = B
  logic              lat_we;

  logic              req_any;
  logic              grant_b;
  logic              accept;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  logic              mem_select_q;
  logic              mem_op_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_data_in_q;
  logic              a_rsp_valid_q;
  logic              b_rsp_valid_q;
  logic [DATA_W-1:0] a_rsp_rdata_q;
  logic [DATA_W-1:0] b_rsp_rdata_q;

  // Round-robin choice and payload mux; acceptance only in IDLE and never under reset
  always_comb begin
    req_any   = bus.a_valid | bus.b_valid;
    grant_b   = bus.b_valid & (~bus.a_valid | ptr);
    accept    = rst_n & (state == IDLE) & req_any;
    sel_we    = grant_b ? bus.b_we    : bus.a_we;
    sel_addr  = grant_b ? bus.b_addr  : bus.a_addr;
    sel_wdata = grant_b ? bus.b_wdata : bus.a_wdata;
  end

  assign bus.a_ready = accept & ~grant_b;
  assign bus.b_ready = accept &  grant_b;
  assign bus.busy    = (state != IDLE);

  // Sequencer state, priority pointer and transaction latch
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      ptr    <= 1'b0;
      gnt_id <= 1'b0;
      lat_we <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state  <= ISSUE;
            gnt_id <= grant_b;
            ptr    <= ~grant_b;
            lat_we <= sel_we;
          end
        end
        ISSUE:   state <= WAIT;
        WAIT:    state <= RESP;
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // memory_unit drive: registered so select is high only during ISSUE; addr/data hold afterwards
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_select_q  <= 1'b0;
      mem_op_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_data_in_q <= '0;
    end else if (accept) begin
      mem_select_q  <= 1'b1;
      mem_op_q      <= sel_we;
      mem_addr_q    <= sel_addr;
      mem_data_in_q <= sel_we ? sel_wdata : '0;
    end else begin
      mem_select_q  <= 1'b0;
      mem_op_q      <= 1'b0;
    end
  end

  // Response pulse, raised on leaving WAIT so it is visible for the single RESP cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_rsp_valid_q <= 1'b0;
      b_rsp_valid_q <= 1'b0;
    end else begin
      a_rsp_valid_q <= (state == WAIT) & ~gnt_id;
      b_rsp_valid_q <= (state == WAIT) &  gnt_id;
    end
  end

  // Read data capture: memory data is valid in WAIT, so the response register loads at its end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_rsp_rdata_q <= '0;
      b_rsp_rdata_q <= '0;
    end else if ((state == WAIT) && !lat_we) begin
      if (gnt_id) begin
        b_rsp_rdata_q <= bus.mem_data_out;
      end else begin
        a_rsp_rdata_q <= bus.mem_data_out;
      end
    end
  end

  assign bus.mem_select  = mem_select_q;
  assign bus.mem_op      = mem_op_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_data_in = mem_data_in_q;
  assign bus.a_rsp_valid = a_rsp_valid_q;
  assign bus.b_rsp_valid = b_rsp_valid_q;
  assign bus.a_rsp_rdata = a_rsp_rdata_q;
  assign bus.b_rsp_rdata = b_rsp_rdata_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: directed scenarios plus random traffic,
// compared cycle by cycle against a transaction-level reference model.
module tb_memory_arbiter;

  localparam int AW = 3;
  localparam int DW = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  memory_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  memory_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Stand-in for memory_unit: write on select, read data registered for the next cycle
  logic [DW-1:0] mem_arr [8] = '{default: '0};
  always @(posedge clk) begin
    if (bus.mem_select) begin
      if (bus.mem_op) mem_arr[bus.mem_addr] <= bus.mem_data_in;
      else            bus.mem_data_out      <= mem_arr[bus.mem_addr];
    end
  end

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } req_t;

  req_t qa[$];
  req_t qb[$];

  // Reference model state
  int            cyc;
  int            m_cnt;
  bit            m_ptr;
  logic [DW-1:0] ref_mem [8];
  int            sel_cyc;
  logic          sel_op;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_data;
  int            rsp_cyc;
  bit            rsp_who;
  bit            rsp_rd;
  logic [DW-1:0] rsp_data;
  logic [AW-1:0] last_addr;
  logic [DW-1:0] last_data;
  logic [DW-1:0] hold_a;
  logic [DW-1:0] hold_b;
  bit            accepted;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_cnt     = 0;
    m_ptr     = 1'b0;
    sel_cyc   = -10;
    rsp_cyc   = -10;
    last_addr = '0;
    last_data = '0;
    hold_a    = '0;
    hold_b    = '0;
  endtask

  task automatic push_req(input bit who, input bit we, input int addr, input int data);
    req_t r;
    r.we    = we;
    r.addr  = AW'(addr);
    r.wdata = DW'(data);
    if (who) qb.push_back(r);
    else     qa.push_back(r);
  endtask

  // One clock cycle: present queue heads, check handshake, advance model, check registered outputs
  task automatic step();
    req_t r;
    bit   ga, gb, rst_seen;
    bus.a_valid = (qa.size() > 0);
    bus.b_valid = (qb.size() > 0);
    if (qa.size() > 0) begin
      bus.a_we = qa[0].we; bus.a_addr = qa[0].addr; bus.a_wdata = qa[0].wdata;
    end else begin
      bus.a_we = 1'($urandom); bus.a_addr = AW'($urandom); bus.a_wdata = DW'($urandom);
    end
    if (qb.size() > 0) begin
      bus.b_we = qb[0].we; bus.b_addr = qb[0].addr; bus.b_wdata = qb[0].wdata;
    end else begin
      bus.b_we = 1'($urandom); bus.b_addr = AW'($urandom); bus.b_wdata = DW'($urandom);
    end
    #1;
    ga = 1'b0;
    gb = 1'b0;
    accepted = 1'b0;
    if (rst_n && m_cnt == 0) begin
      if (qa.size() > 0 && (qb.size() == 0 || !m_ptr)) ga = 1'b1;
      else if (qb.size() > 0)                           gb = 1'b1;
    end
    check("a_ready", 32'(bus.a_ready), 32'(ga));
    check("b_ready", 32'(bus.b_ready), 32'(gb));
    if (ga || gb) begin
      r        = ga ? qa.pop_front() : qb.pop_front();
      sel_cyc  = cyc + 1;
      sel_op   = r.we;
      sel_addr = r.addr;
      sel_data = r.we ? r.wdata : '0;
      rsp_cyc  = cyc + 3;
      rsp_who  = gb;
      rsp_rd   = !r.we;
      rsp_data = ref_mem[r.addr];
      if (r.we) ref_mem[r.addr] = r.wdata;
      m_ptr    = ga;
      m_cnt    = 3;
      accepted = 1'b1;
    end else if (m_cnt > 0) begin
      m_cnt--;
    end
    rst_seen = !rst_n;
    @(posedge clk);
    #1;
    cyc++;
    if (rst_seen) model_reset();
    if (cyc == sel_cyc) begin
      last_addr = sel_addr;
      last_data = sel_data;
    end
    if (cyc == rsp_cyc && rsp_rd) begin
      if (rsp_who) hold_b = rsp_data;
      else         hold_a = rsp_data;
    end
    check("busy",        32'(bus.busy),        32'(m_cnt > 0));
    check("mem_select",  32'(bus.mem_select),  32'(cyc == sel_cyc));
    check("mem_op",      32'(bus.mem_op),      32'((cyc == sel_cyc) && sel_op));
    check("mem_addr",    32'(bus.mem_addr),    32'(last_addr));
    check("mem_data_in", 32'(bus.mem_data_in), 32'(last_data));
    check("a_rsp_valid", 32'(bus.a_rsp_valid), 32'((cyc == rsp_cyc) && !rsp_who));
    check("b_rsp_valid", 32'(bus.b_rsp_valid), 32'((cyc == rsp_cyc) && rsp_who));
    check("a_rsp_rdata", 32'(bus.a_rsp_rdata), 32'(hold_a));
    check("b_rsp_rdata", 32'(bus.b_rsp_rdata), 32'(hold_b));
  endtask

  // Run until both queues are served and the model is idle, within a cycle budget
  task automatic drain();
    int n;
    n = 0;
    while ((qa.size() > 0 || qb.size() > 0 || m_cnt > 0) && n < 400) begin
      step();
      n++;
    end
    check("drain_done", 32'(qa.size() + qb.size() + m_cnt), 32'(0));
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    int n;
    cyc = 0;
    for (int i = 0; i < 8; i++) ref_mem[i] = '0;
    model_reset();
    bus.a_valid = 1'b0; bus.a_we = 1'b0; bus.a_addr = '0; bus.a_wdata = '0;
    bus.b_valid = 1'b0; bus.b_we = 1'b0; bus.b_addr = '0; bus.b_wdata = '0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    step();
    step();
    rst_n = 1'b1;

    // Write then read across requesters
    push_req(0, 1, 0, 8'h6D);
    drain();
    push_req(1, 0, 0, 0);
    drain();
    check("b_read_0x6D", 32'(bus.b_rsp_rdata), 32'h6D);

    // Simultaneous requests after reset
    reset_pulse();
    push_req(0, 1, 1, 8'h6F);
    push_req(1, 1, 2, 8'h72);
    drain();
    push_req(0, 0, 1, 0);
    push_req(1, 0, 2, 0);
    drain();
    check("a_read_0x6F", 32'(bus.a_rsp_rdata), 32'h6F);
    check("b_read_0x72", 32'(bus.b_rsp_rdata), 32'h72);

    // Fairness under contention
    for (int i = 0; i < 4; i++) begin
      push_req(0, 1'($urandom), int'($urandom_range(0, 7)), int'($urandom_range(0, 255)));
      push_req(1, 1'($urandom), int'($urandom_range(0, 7)), int'($urandom_range(0, 255)));
    end
    drain();

    // Single requester back-to-back
    push_req(0, 1, 3, 8'h74);
    push_req(0, 1, 4, 8'h65);
    push_req(0, 1, 5, 8'h6E);
    push_req(0, 0, 3, 0);
    push_req(0, 0, 4, 0);
    push_req(0, 0, 5, 0);
    drain();
    check("a_read_0x6E", 32'(bus.a_rsp_rdata), 32'h6E);

    // Boundary address
    push_req(0, 1, 7, 8'hFF);
    push_req(0, 0, 7, 0);
    drain();
    check("a_read_0xFF", 32'(bus.a_rsp_rdata), 32'hFF);
    push_req(1, 0, 0, 0);
    drain();

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      if (qa.size() == 0 && $urandom_range(0, 99) < 50)
        push_req(0, 1'($urandom), int'($urandom_range(0, 7)), int'($urandom_range(0, 255)));
      if (qb.size() == 0 && $urandom_range(0, 99) < 50)
        push_req(1, 1'($urandom), int'($urandom_range(0, 7)), int'($urandom_range(0, 255)));
      step();
    end
    drain();

    // Reset mid-operation: read from A, reset during WAIT, then both request
    push_req(0, 0, 7, 0);
    n = 0;
    do begin
      step();
      n++;
    end while (!accepted && n < 20);
    check("midrst_accept", 32'(accepted), 32'(1));
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("midrst_busy",   32'(bus.busy),        32'(0));
    check("midrst_select", 32'(bus.mem_select),  32'(0));
    check("midrst_a_rsp",  32'(bus.a_rsp_valid), 32'(0));
    for (int i = 0; i < 4; i++) step();
    push_req(0, 0, 1, 0);
    push_req(1, 0, 2, 0);
    step();
    check("midrst_a_first", 32'(bus.a_rsp_valid | bus.busy), 32'(1));
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Two-requester arbiter and sequencer for the 8x8 `memory_unit`. It accepts read and write requests from two independent requesters (A and B) over a valid/ready handshake and grants them round-robin. It drives the `memory_unit` `select`/`op`/`addr`/`data_in` pins and returns read data or a write acknowledge to the granted requester. It sits between the datapath clients and the single `memory_unit` instance, which it owns exclusively.

## Interface
- `ADDR_W`, 3, address width; must match `memory_unit` (8 words).
- `DATA_W`, 8, data width; must match `memory_unit`.

Ports:
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `a_valid`, `b_valid`  in  1  request present; held with payload stable until `*_ready`.
- `a_ready`, `b_ready`  out  1  request accepted this cycle (combinational).
- `a_we`, `b_we`  in  1  1 = write, 0 = read.
- `a_addr`, `b_addr`  in  ADDR_W  word address.
- `a_wdata`, `b_wdata`  in  DATA_W  write data; ignored for reads.
- `a_rsp_valid`, `b_rsp_valid`  out  1  one-cycle response pulse.
- `a_rsp_rdata`, `b_rsp_rdata`  out  DATA_W  read data; valid with `*_rsp_valid` on reads.
- `mem_select`  out  1  to `memory_unit.select`.
- `mem_op`  out  1  to `memory_unit.op` (1 = write, 0 = read).
- `mem_addr`  out  ADDR_W  to `memory_unit.addr`.
- `mem_data_in`  out  DATA_W  to `memory_unit.data_in`.
- `mem_data_out`  in  DATA_W  from `memory_unit.data_out`.
- `busy`  out  1  state != IDLE.

## Operation
- FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE. Reads and writes follow the same path.
- **IDLE.** If any `*_valid` is high, grant exactly one requester and assert its `*_ready`. Latch `we`, `addr`, `wdata` and the grant ID, then go to ISSUE. With no valid, stay in IDLE.
- **Arbitration.** Round-robin with a 1-bit priority pointer.
  - Both valid: the requester the pointer names wins.
  - Only one valid: that requester wins regardless of the pointer.
  - After every grant, the pointer moves to the non-granted requester.
  - Reset value of the pointer: A.
- **ISSUE.** Assert `mem_select=1` and `mem_op=we`; drive `mem_addr` and `mem_data_in` from the latch (`mem_data_in=0` for reads). This is the single cycle in which `mem_select` is high.
- **WAIT.** Deassert `mem_select`. On reads, capture `mem_data_out` into the response register. The `memory_unit` read data is valid in the cycle after the issue cycle.
- **RESP.** Pulse the granted requester's `*_rsp_valid` for exactly one cycle.
  - Read: drive `*_rsp_rdata` with the captured value.
  - Write: the pulse is the write acknowledge, and `*_rsp_rdata` is unchanged.
  - Next state is IDLE.
- `*_rsp_rdata` holds its last read value until the next read response to that requester.
- The non-granted requester never sees `*_ready` or `*_rsp_valid`.
- `*_ready` is never asserted outside IDLE.
- `mem_addr` / `mem_data_in` hold their last values when `mem_select=0`; `mem_op` returns to 0 when `mem_select=0`.

## Timing
- **Reset** (`rst_n` low at a rising edge), values from the next cycle:
  - state IDLE, pointer A.
  - `mem_select`, `mem_op`, `mem_addr`, `mem_data_in` = 0.
  - `*_rsp_valid`, `*_rsp_rdata`, `busy` = 0.
  - `*_ready` = 0 while `rst_n` is low.
- **Latency.** With acceptance in cycle N: `mem_select` high in N+1, data captured in N+2, `*_rsp_valid` in N+3, next acceptance possible in N+4.
- **Throughput.** One transaction per 4 cycles.
- **Reset mid-operation.** The in-flight transaction is dropped. No `*_rsp_valid` is produced for it and `mem_select` goes low on the next cycle. A write already issued in ISSUE may have reached memory; nothing else is guaranteed.
- Arbitration uses `*_valid` in the IDLE cycle only. A requester that drops `valid` before `ready` is not served.
- Addresses wrap naturally modulo 2^ADDR_W; no range checking is done.

## Test plan
- **Write then read across requesters.** A writes 0x6D to addr 0; after A's `rsp_valid`, B reads addr 0. Required: `mem_select` high exactly 1 cycle per transaction, and B gets `b_rsp_rdata=0x6D` with `b_rsp_valid` 3 cycles after `b_ready`.
- **Simultaneous requests after reset.** A writes 0x6F to addr 1 and B writes 0x72 to addr 2, both valid in the same IDLE cycle. Required: A is granted first, B is granted 4 cycles later, then reads of addr 1 and 2 return 0x6F and 0x72.
- **Fairness under contention.** A and B both keep `valid` asserted for 8 transactions. Required: grants strictly alternate A, B, A, B, … and `*_ready` appears every 4 cycles.
- **Single requester back-to-back.** Only A requests: writes 0x74, 0x65, 0x6E to addrs 3, 4, 5, then reads them back. Required: consecutive A grants every 4 cycles with no B cycle inserted, and reads return 0x74, 0x65, 0x6E.
- **Boundary address.** Write 0xFF to addr 7, then read addr 7. Required: read returns 0xFF and addr 0 is unaffected.
- **Reset mid-operation.** A starts a read, and `rst_n` is driven low during WAIT for one cycle. Required:
  - no `a_rsp_valid` for that read; `busy`, `mem_select` and all outputs are 0 after the reset edge;
  - the pointer is back at A: with both requesters then valid, A is granted first.
